// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types for the RC4 keystream consumer.
//   BYTE_W          - data byte width
//   rc4_xor_state_t - control FSM states of rc4_stream_xor
//   rc4_byte_t      - one data / keystream byte
package rc4_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        RUN,
        DONE
    } rc4_xor_state_t;

    typedef logic [BYTE_W-1:0] rc4_byte_t;

endpackage

// File: rtl/rc4_byte_fifo.sv
// rc4_byte_fifo: small synchronous byte FIFO used to prefetch keystream.
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   flush_i        - synchronous flush, empties the FIFO (wins over push/pop)
//   push_i, data_i - write a byte (ignored when full)
//   pop_i          - drop the head byte (ignored when empty)
//   data_o         - head byte, valid while !empty_o
//   empty_o/full_o - occupancy flags
// Reads are not bypassed: a byte written into an empty FIFO shows up on
// data_o the cycle after the push.
module rc4_byte_fifo
    import rc4_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  rc4_byte_t data_i,
    input  logic      pop_i,
    output rc4_byte_t data_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rc4_byte_t   r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        empty_o = (r_wr_ptr == r_rd_ptr);
        full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_push  = push_i && !full_o;
        w_pop   = pop_i && !empty_o;
        data_o  = r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: pulls RC4 keystream bytes and XORs them onto a byte stream.
//   clk_i, rst_i                   - clock, asynchronous active-high reset
//   start_i, len_i                 - start a message of len_i bytes (IDLE only)
//   abort_i                        - synchronous abort back to IDLE, flushes state
//   key_ready_i                    - generator key schedule complete
//   ks_valid_i/ks_data_i/ks_ready_o - keystream input handshake
//   din_valid_i/din_i/din_ready_o  - ciphertext (or plaintext) input handshake
//   dout_valid_o/dout_o/dout_ready_i - registered result stream
//   busy_o                         - FSM not in IDLE
//   done_o                         - one-cycle pulse once the last byte is taken
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int unsigned KS_DEPTH = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             key_ready_i,
    input  logic             ks_valid_i,
    input  logic [7:0]       ks_data_i,
    output logic             ks_ready_o,
    input  logic             din_valid_i,
    input  logic [7:0]       din_i,
    output logic             din_ready_o,
    output logic             dout_valid_o,
    output logic [7:0]       dout_o,
    input  logic             dout_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    rc4_xor_state_t   r_state;
    rc4_xor_state_t   w_state_next;
    logic [LEN_W-1:0] r_rem_cnt;    // bytes still to be produced
    logic [LEN_W-1:0] r_fetch_cnt;  // keystream bytes still to be fetched
    rc4_byte_t        r_dout;
    logic             r_dout_valid;

    logic             w_fifo_empty;
    logic             w_fifo_full;
    rc4_byte_t        w_ks_head;
    logic             w_out_free;
    logic             w_ks_fire;
    logic             w_din_fire;

    rc4_byte_fifo #(
        .DEPTH (KS_DEPTH)
    ) u_ks_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (abort_i),
        .push_i  (w_ks_fire),
        .data_i  (ks_data_i),
        .pop_i   (w_din_fire),
        .data_o  (w_ks_head),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    // Handshakes. Fetch is bounded by fetch_cnt so the generator is never
    // advanced past the message, keeping later messages aligned.
    always_comb begin
        w_out_free  = !r_dout_valid || dout_ready_i;
        ks_ready_o  = (r_state == RUN) && !w_fifo_full && (r_fetch_cnt != '0);
        din_ready_o = (r_state == RUN) && !w_fifo_empty && (r_rem_cnt != '0) &&
                      w_out_free;
        w_ks_fire   = ks_valid_i && ks_ready_o;
        w_din_fire  = din_valid_i && din_ready_o;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0)      w_state_next = DONE;
                    else if (key_ready_i) w_state_next = RUN;
                    else                  w_state_next = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (key_ready_i) w_state_next = RUN;
            end
            RUN: begin
                // Leave only once the final output byte has been accepted.
                if ((r_rem_cnt == '0) && w_out_free) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (abort_i) w_state_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rem_cnt   <= '0;
            r_fetch_cnt <= '0;
        end else if (abort_i) begin
            r_rem_cnt   <= '0;
            r_fetch_cnt <= '0;
        end else if ((r_state == IDLE) && start_i) begin
            r_rem_cnt   <= len_i;
            r_fetch_cnt <= len_i;
        end else begin
            if (w_ks_fire)  r_fetch_cnt <= r_fetch_cnt - LEN_W'(1);
            if (w_din_fire) r_rem_cnt   <= r_rem_cnt - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (abort_i) begin
            r_dout_valid <= 1'b0;
        end else if (w_din_fire) begin
            r_dout       <= din_i ^ w_ks_head;
            r_dout_valid <= 1'b1;
        end else if (dout_ready_i) begin
            r_dout_valid <= 1'b0;
        end
    end

    always_comb begin
        dout_o       = r_dout;
        dout_valid_o = r_dout_valid;
        busy_o       = (r_state != IDLE);
        done_o       = (r_state == DONE);
    end

endmodule
